// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one unified memory bus between the instruction-fetch
// port (I) and the data-access port (D) of the multicycle core. Only one
// transaction is in flight at a time. D has fixed priority over I, but once D
// has been granted STARVE_LIMIT times in a row while I was waiting, the next
// arbitration goes to I.

module mem_bus_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,

   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,

   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_ready,
   input  logic              m_rvalid,
   input  logic [DATA_W-1:0] m_rdata,

   output logic              owner,
   output logic              busy,
   output logic              err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t     state;
   logic [3:0] starve_cnt;
   logic       accept;
   logic       complete;
   logic       pick_d;

   // Bus handshake decode and the arbitration decision taken when idle
   always_comb begin
      accept   = (state == REQ) && m_ready;
      complete = m_rvalid && (accept || (state == RESP));
      pick_d   = d_req && !(i_req && (starve_cnt == LIMIT));
   end

   assign m_req    = (state == REQ);
   assign busy     = (state != IDLE);
   assign i_gnt    = accept && !owner;
   assign d_gnt    = accept && owner;
   assign i_rvalid = complete && !owner;
   assign d_rvalid = complete && owner;
   assign i_rdata  = m_rdata;
   assign d_rdata  = m_rdata;

   // A completion that arrives with no transaction able to take it is flagged;
   // the reset term keeps err quiet while the block is held in reset
   assign err = reset && m_rvalid &&
                ((state == IDLE) || ((state == REQ) && !m_ready));

   // Transaction FSM: arbitrate and capture in IDLE, present the request in REQ,
   // wait for the completion in RESP
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         owner   <= 1'b0;
         m_we    <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_req || d_req) begin
                  state   <= REQ;
                  owner   <= pick_d;
                  m_we    <= pick_d && d_we;
                  m_addr  <= pick_d ? d_addr : i_addr;
                  m_wdata <= pick_d ? d_wdata : '0;
               end
            end
            REQ: begin
               if (accept) begin
                  state <= m_rvalid ? IDLE : RESP;
               end
            end
            RESP: begin
               if (m_rvalid) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Starvation counter: counts D grants taken while I waits, cleared once I is
   // served or whenever I stops asking
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else if (d_gnt && i_req) begin
         if (starve_cnt < LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
         end
      end else if (i_gnt || !i_req) begin
         starve_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus a randomized run of both
// requesters against a transaction-level model of the arbiter.

module tb_mem_bus_arbiter;

   localparam int STARVE_LIMIT = 4;

   logic        clk;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_ready;
   logic        m_rvalid;
   logic [31:0] m_rdata;
   logic        owner;
   logic        busy;
   logic        err;

   int checks;
   int errors;

   mem_bus_arbiter #(
      .ADDR_W(32),
      .DATA_W(32),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .i_req(i_req),
      .i_addr(i_addr),
      .i_gnt(i_gnt),
      .i_rvalid(i_rvalid),
      .i_rdata(i_rdata),
      .d_req(d_req),
      .d_we(d_we),
      .d_addr(d_addr),
      .d_wdata(d_wdata),
      .d_gnt(d_gnt),
      .d_rvalid(d_rvalid),
      .d_rdata(d_rdata),
      .m_req(m_req),
      .m_we(m_we),
      .m_addr(m_addr),
      .m_wdata(m_wdata),
      .m_ready(m_ready),
      .m_rvalid(m_rvalid),
      .m_rdata(m_rdata),
      .owner(owner),
      .busy(busy),
      .err(err)
   );

   // Free-running clock, rising edge active
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so a stuck run still ends with a report
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "[TB] watchdog");
   end

   // Hold reset for two cycles with every input idle, release at a falling edge
   task do_reset;
      @(negedge clk);
      reset    = 1'b0;
      i_req    = 1'b0;
      i_addr   = '0;
      d_req    = 1'b0;
      d_we     = 1'b0;
      d_addr   = '0;
      d_wdata  = '0;
      m_ready  = 1'b0;
      m_rvalid = 1'b0;
      m_rdata  = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task test_reset;
      @(negedge clk);
      reset   = 1'b0;
      i_req   = 1'b1;
      i_addr  = 32'h0;
      m_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         m_rvalid = (c == 1);
         #1;
         checks++;
         if ({m_req, busy, err, i_gnt, i_rvalid} !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL reset_hold c=%0d: req/busy/err/gnt/rvalid=%b expected 00000", c, {m_req, busy, err, i_gnt, i_rvalid});
         end
         @(negedge clk);
      end
      m_rvalid = 1'b0;
      reset    = 1'b1;
      #1;
      checks++;
      if (m_req !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_release_no_edge: m_req=%b expected 0", m_req);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({m_req, busy, owner, m_we, m_addr} !== {4'b1100, 32'h0}) begin
         errors++;
         $display("[TB] FAIL reset_first_req: req/busy/owner/we=%b addr=%h expected 1100 addr=00000000", {m_req, busy, owner, m_we}, m_addr);
      end
   endtask

   task test_single_read;
      int gnt_seen;
      gnt_seen = 0;
      do_reset;
      @(negedge clk);
      i_req   = 1'b1;
      i_addr  = 32'hBFC00004;
      m_ready = 1'b1;
      #1;
      gnt_seen += int'(i_gnt);
      checks++;
      if ({m_req, busy} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL read_idle: m_req/busy=%b expected 00", {m_req, busy});
      end
      @(negedge clk);
      #1;
      gnt_seen += int'(i_gnt);
      checks++;
      if ({m_req, m_we, i_gnt, d_gnt, i_rvalid, m_addr} !== {5'b10100, 32'hBFC00004}) begin
         errors++;
         $display("[TB] FAIL read_req: req/we/ig/dg/irv=%b addr=%h expected 10100 addr=bfc00004", {m_req, m_we, i_gnt, d_gnt, i_rvalid}, m_addr);
      end
      @(negedge clk);
      i_req  = 1'b0;
      i_addr = '0;
      #1;
      gnt_seen += int'(i_gnt);
      checks++;
      if ({m_req, busy, i_rvalid, d_rvalid} !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL read_wait: req/busy/irv/drv=%b expected 0100", {m_req, busy, i_rvalid, d_rvalid});
      end
      @(negedge clk);
      m_rvalid = 1'b1;
      m_rdata  = 32'h24080005;
      #1;
      gnt_seen += int'(i_gnt);
      checks++;
      if ({i_rvalid, d_rvalid, i_rdata} !== {2'b10, 32'h24080005}) begin
         errors++;
         $display("[TB] FAIL read_data: irv/drv=%b rdata=%h expected 10 rdata=24080005", {i_rvalid, d_rvalid}, i_rdata);
      end
      @(negedge clk);
      m_rvalid = 1'b0;
      #1;
      gnt_seen += int'(i_gnt);
      checks++;
      if ({busy, i_rvalid, d_rvalid} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL read_done: busy/irv/drv=%b expected 000", {busy, i_rvalid, d_rvalid});
      end
      checks++;
      if (gnt_seen != 1) begin
         errors++;
         $display("[TB] FAIL read_gnt_count: saw %0d i_gnt pulses expected 1", gnt_seen);
      end
   endtask

   task test_priority;
      int got[$];
      int exp_seq[$];
      int s;
      got.delete();
      exp_seq.delete();
      s = 0;
      for (int k = 0; k < 10; k++) begin
         if (s == STARVE_LIMIT) begin
            exp_seq.push_back(0);
            s = 0;
         end else begin
            exp_seq.push_back(1);
            s++;
         end
      end
      do_reset;
      @(negedge clk);
      i_req    = 1'b1;
      i_addr   = 32'h00000100;
      d_req    = 1'b1;
      d_we     = 1'b1;
      d_addr   = 32'h00000010;
      d_wdata  = 32'hDEADBEEF;
      m_ready  = 1'b1;
      m_rvalid = 1'b1;
      for (int cyc = 0; cyc < 80 && got.size() < 10; cyc++) begin
         #1;
         if (i_gnt) got.push_back(0);
         if (d_gnt) got.push_back(1);
         if (d_gnt) begin
            checks++;
            if ({m_we, d_rvalid, m_addr, m_wdata} !== {2'b11, 32'h10, 32'hDEADBEEF}) begin
               errors++;
               $display("[TB] FAIL prio_d_fields: we/rv=%b addr=%h wdata=%h expected 11 00000010 deadbeef", {m_we, d_rvalid}, m_addr, m_wdata);
            end
         end
         if (i_gnt) begin
            checks++;
            if ({m_we, i_rvalid, m_addr} !== {2'b01, 32'h100}) begin
               errors++;
               $display("[TB] FAIL prio_i_fields: we/rv=%b addr=%h expected 01 00000100", {m_we, i_rvalid}, m_addr);
            end
         end
         @(negedge clk);
      end
      checks++;
      if (got.size() != 10) begin
         errors++;
         $display("[TB] FAIL prio_timeout: saw %0d grants expected 10", got.size());
      end else begin
         for (int k = 0; k < 10; k++) begin
            checks++;
            if (got[k] != exp_seq[k]) begin
               errors++;
               $display("[TB] FAIL prio_order[%0d]: got %s expected %s", k, got[k] ? "D" : "I", exp_seq[k] ? "D" : "I");
            end
         end
      end
   endtask

   task test_backpressure;
      do_reset;
      @(negedge clk);
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h00002000;
      d_wdata = 32'hCAFEF00D;
      m_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if ({m_req, m_we, owner, i_gnt, d_gnt, m_addr, m_wdata} !== {5'b11100, 32'h2000, 32'hCAFEF00D}) begin
            errors++;
            $display("[TB] FAIL bp_stall c=%0d: req/we/own/ig/dg=%b addr=%h wdata=%h expected 11100 00002000 cafef00d",
                     c, {m_req, m_we, owner, i_gnt, d_gnt}, m_addr, m_wdata);
         end
      end
      @(negedge clk);
      m_ready = 1'b1;
      #1;
      checks++;
      if ({i_gnt, d_gnt, d_rvalid} !== 3'b010) begin
         errors++;
         $display("[TB] FAIL bp_accept: ig/dg/drv=%b expected 010", {i_gnt, d_gnt, d_rvalid});
      end
      @(negedge clk);
      d_req    = 1'b0;
      m_ready  = 1'b0;
      m_rvalid = 1'b1;
      #1;
      checks++;
      if ({m_req, d_gnt, d_rvalid} !== 3'b001) begin
         errors++;
         $display("[TB] FAIL bp_complete: req/dg/drv=%b expected 001", {m_req, d_gnt, d_rvalid});
      end
      @(negedge clk);
      m_rvalid = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_idle: busy=%b expected 0", busy);
      end
   endtask

   task test_combined_err;
      do_reset;
      @(negedge clk);
      i_req  = 1'b1;
      i_addr = 32'h00000400;
      @(negedge clk);
      m_ready  = 1'b1;
      m_rvalid = 1'b1;
      m_rdata  = 32'h00001234;
      #1;
      checks++;
      if ({i_gnt, i_rvalid, d_rvalid, err, i_rdata} !== {4'b1100, 32'h1234}) begin
         errors++;
         $display("[TB] FAIL comb_accept: ig/irv/drv/err=%b rdata=%h expected 1100 00001234", {i_gnt, i_rvalid, d_rvalid, err}, i_rdata);
      end
      @(negedge clk);
      i_req    = 1'b0;
      m_ready  = 1'b0;
      m_rvalid = 1'b0;
      #1;
      checks++;
      if ({busy, m_req} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL comb_idle: busy/req=%b expected 00", {busy, m_req});
      end
      @(negedge clk);
      m_rvalid = 1'b1;
      #1;
      checks++;
      if ({err, i_rvalid, d_rvalid, busy} !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL err_idle: err/irv/drv/busy=%b expected 1000", {err, i_rvalid, d_rvalid, busy});
      end
      @(negedge clk);
      m_rvalid = 1'b0;
      d_req    = 1'b1;
      d_we     = 1'b0;
      d_addr   = 32'h00000030;
      #1;
      checks++;
      if ({err, busy} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL err_clear: err/busy=%b expected 00", {err, busy});
      end
      @(negedge clk);
      m_rvalid = 1'b1;
      #1;
      checks++;
      if ({err, d_rvalid, d_gnt, m_req} !== 4'b1001) begin
         errors++;
         $display("[TB] FAIL err_req: err/drv/dg/req=%b expected 1001", {err, d_rvalid, d_gnt, m_req});
      end
      @(negedge clk);
      m_rvalid = 1'b0;
      m_ready  = 1'b1;
      #1;
      checks++;
      if ({err, d_gnt, m_req, m_addr} !== {3'b011, 32'h30}) begin
         errors++;
         $display("[TB] FAIL err_recover: err/dg/req=%b addr=%h expected 011 00000030", {err, d_gnt, m_req}, m_addr);
      end
   endtask

   task test_mid_reset;
      do_reset;
      @(negedge clk);
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h00000050;
      @(negedge clk);
      m_ready = 1'b1;
      #1;
      checks++;
      if (d_gnt !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_gnt: d_gnt=%b expected 1", d_gnt);
      end
      @(negedge clk);
      d_req   = 1'b0;
      m_ready = 1'b0;
      #1;
      checks++;
      if ({busy, owner, m_req} !== 3'b110) begin
         errors++;
         $display("[TB] FAIL mid_resp: busy/owner/req=%b expected 110", {busy, owner, m_req});
      end
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if ({busy, m_req, owner, d_rvalid, d_gnt, m_addr} !== {5'b00000, 32'h0}) begin
         errors++;
         $display("[TB] FAIL mid_async_clear: busy/req/own/drv/dg=%b addr=%h expected 00000 00000000", {busy, m_req, owner, d_rvalid, d_gnt}, m_addr);
      end
      m_rvalid = 1'b1;
      #1;
      checks++;
      if ({d_rvalid, err} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL mid_dropped: drv/err=%b expected 00", {d_rvalid, err});
      end
      @(negedge clk);
      m_rvalid = 1'b0;
      reset    = 1'b1;
      d_req    = 1'b1;
      d_addr   = 32'h00000060;
      #1;
      checks++;
      if ({busy, d_rvalid} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL mid_release: busy/drv=%b expected 00", {busy, d_rvalid});
      end
      @(negedge clk);
      m_ready = 1'b1;
      #1;
      checks++;
      if ({m_req, owner, d_gnt, m_addr} !== {3'b111, 32'h60}) begin
         errors++;
         $display("[TB] FAIL mid_fresh_req: req/own/dg=%b addr=%h expected 111 00000060", {m_req, owner, d_gnt}, m_addr);
      end
      @(negedge clk);
      d_req    = 1'b0;
      m_ready  = 1'b0;
      m_rvalid = 1'b1;
      m_rdata  = 32'h00000077;
      #1;
      checks++;
      if ({d_rvalid, d_rdata} !== {1'b1, 32'h77}) begin
         errors++;
         $display("[TB] FAIL mid_fresh_data: drv=%b rdata=%h expected 1 00000077", d_rvalid, d_rdata);
      end
      @(negedge clk);
      m_rvalid = 1'b0;
   endtask

   // Randomized traffic: the bench plays both requesters and the memory, and a
   // transaction-level model predicts every cycle's handshake outputs
   task test_random;
      logic        i_pend, d_pend;
      logic        mdl_busy, mdl_granted, mdl_owner, mdl_we;
      logic [31:0] mdl_addr, mdl_wdata;
      logic        exp_req, exp_ig, exp_dg, exp_ir, exp_dr, exp_err, done, d_wins;
      int          streak, i_grants, d_grants;
      do_reset;
      i_pend = 1'b0;
      d_pend = 1'b0;
      mdl_busy = 1'b0;
      mdl_granted = 1'b0;
      mdl_owner = 1'b0;
      mdl_we = 1'b0;
      mdl_addr = '0;
      mdl_wdata = '0;
      streak = 0;
      i_grants = 0;
      d_grants = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         if (!i_pend && $urandom_range(0, 2) == 0) begin
            i_pend = 1'b1;
            i_addr = $urandom;
         end
         if (!d_pend && $urandom_range(0, 2) == 0) begin
            d_pend  = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = $urandom;
            d_wdata = $urandom;
         end
         i_req   = i_pend;
         d_req   = d_pend;
         m_ready = ($urandom_range(0, 3) != 0);
         m_rdata = $urandom;
         if (mdl_busy && mdl_granted)
            m_rvalid = ($urandom_range(0, 2) == 0);
         else if (mdl_busy && m_ready)
            m_rvalid = ($urandom_range(0, 3) == 0);
         else if (mdl_busy)
            m_rvalid = ($urandom_range(0, 9) == 0);
         else if (!i_pend && !d_pend)
            m_rvalid = ($urandom_range(0, 9) == 0);
         else
            m_rvalid = 1'b0;

         exp_req = mdl_busy && !mdl_granted;
         exp_ig  = exp_req && m_ready && !mdl_owner;
         exp_dg  = exp_req && m_ready && mdl_owner;
         done    = mdl_busy && m_rvalid && (mdl_granted || m_ready);
         exp_ir  = done && !mdl_owner;
         exp_dr  = done && mdl_owner;
         exp_err = m_rvalid && (!mdl_busy || (exp_req && !m_ready));
         #1;
         checks++;
         if ({m_req, i_gnt, d_gnt, i_rvalid, d_rvalid, err, busy} !== {exp_req, exp_ig, exp_dg, exp_ir, exp_dr, exp_err, mdl_busy}) begin
            errors++;
            $display("[TB] FAIL rand_ctrl cyc=%0d: req/ig/dg/irv/drv/err/busy=%b expected %b", cyc,
                     {m_req, i_gnt, d_gnt, i_rvalid, d_rvalid, err, busy},
                     {exp_req, exp_ig, exp_dg, exp_ir, exp_dr, exp_err, mdl_busy});
         end
         if (exp_req) begin
            checks++;
            if ({owner, m_we, m_addr, m_wdata} !== {mdl_owner, mdl_we, mdl_addr, mdl_wdata}) begin
               errors++;
               $display("[TB] FAIL rand_bus cyc=%0d: own/we=%b addr=%h wdata=%h expected %b %h %h", cyc,
                        {owner, m_we}, m_addr, m_wdata, {mdl_owner, mdl_we}, mdl_addr, mdl_wdata);
            end
         end
         if (done) begin
            checks++;
            if ((mdl_owner ? d_rdata : i_rdata) !== m_rdata) begin
               errors++;
               $display("[TB] FAIL rand_rdata cyc=%0d: rdata=%h expected %h", cyc, mdl_owner ? d_rdata : i_rdata, m_rdata);
            end
         end

         if (!mdl_busy) begin
            if (i_pend || d_pend) begin
               d_wins      = d_pend && !(i_pend && streak == STARVE_LIMIT);
               mdl_busy    = 1'b1;
               mdl_granted = 1'b0;
               mdl_owner   = d_wins;
               mdl_we      = d_wins && d_we;
               mdl_addr    = d_wins ? d_addr : i_addr;
               mdl_wdata   = d_wins ? d_wdata : 32'h0;
            end
         end else if (!mdl_granted) begin
            if (m_ready) begin
               mdl_granted = 1'b1;
               if (mdl_owner) begin
                  d_pend = 1'b0;
                  d_grants++;
               end else begin
                  i_pend = 1'b0;
                  i_grants++;
               end
               if (m_rvalid) mdl_busy = 1'b0;
            end
         end else if (m_rvalid) begin
            mdl_busy = 1'b0;
         end

         if (exp_dg && i_req) begin
            if (streak < STARVE_LIMIT) streak++;
         end else if (exp_ig || !i_req) begin
            streak = 0;
         end
      end
      checks++;
      if (i_grants == 0 || d_grants == 0) begin
         errors++;
         $display("[TB] FAIL rand_coverage: i_grants=%0d d_grants=%0d expected both nonzero", i_grants, d_grants);
      end
   endtask

   // Scenario sequence and the closing summary
   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b0;
      i_req    = 1'b0;
      i_addr   = '0;
      d_req    = 1'b0;
      d_we     = 1'b0;
      d_addr   = '0;
      d_wdata  = '0;
      m_ready  = 1'b0;
      m_rvalid = 1'b0;
      m_rdata  = '0;
      test_reset;
      test_single_read;
      test_priority;
      test_backpressure;
      test_combined_err;
      test_mid_reset;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
